// File: rtl/seg7_pkg.sv
// Shared constants and the hex glyph table for the seven-segment display driver.
package seg7_pkg;
    localparam int SEG7_W = 7;
    localparam logic [SEG7_W-1:0] SEG7_BLANK = 7'h00;

    // Active-high segments {g,f,e,d,c,b,a}
    function automatic logic [SEG7_W-1:0] seg7_glyph(input logic [3:0] nibble);
        case (nibble)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h06;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h4F;
            4'h4:    return 7'h66;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h7D;
            4'h7:    return 7'h07;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h6F;
            4'hA:    return 7'h77;
            4'hB:    return 7'h7C;
            4'hC:    return 7'h39;
            4'hD:    return 7'h5E;
            4'hE:    return 7'h79;
            default: return 7'h71;
        endcase
    endfunction
endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load bus into the scan driver and the pin-side outputs it returns.
interface seg7_scan_driver_if #(parameter int N_DIGITS = 4);
    import seg7_pkg::*;

    logic                    load;
    logic [4*N_DIGITS-1:0]   value;
    logic [N_DIGITS-1:0]     dp_in;
    logic [SEG7_W-1:0]       seg;
    logic                    dp;
    logic [N_DIGITS-1:0]     sel;
    logic                    frame_tick;

    modport master (output load, value, dp_in, input seg, dp, sel, frame_tick);
    modport slave  (input load, value, dp_in, output seg, dp, sel, frame_tick);
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high seven-segment glyph.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0]        nibble,
    output logic [SEG7_W-1:0] glyph
);
    assign glyph = seg7_glyph(nibble);
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with frame-aligned display updates.
// Optional leading-zero blanking when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS        = 4,
    parameter int SCAN_DIV        = 50000,
    parameter bit SEG_ACTIVE_HIGH = 1'b1,
    parameter bit SEL_ACTIVE_HIGH = 1'b1
) (
    input logic                clk,
    input logic                rst,
    seg7_scan_driver_if.slave  bus
);
    localparam int PS_W  = $clog2(SCAN_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [SEG7_W-1:0]   SEG_XOR = {SEG7_W{!SEG_ACTIVE_HIGH}};
    localparam logic                DP_XOR  = !SEG_ACTIVE_HIGH;
    localparam logic [N_DIGITS-1:0] SEL_XOR = {N_DIGITS{!SEL_ACTIVE_HIGH}};

    typedef struct packed {
        logic [4*N_DIGITS-1:0] value;
        logic [N_DIGITS-1:0]   dp;
    } frame_t;

    logic [PS_W-1:0]     prescaler;
    logic [IDX_W-1:0]    idx;
    frame_t              pending, display;
    logic                tc, last, wrap;
    logic [3:0]          nibble;
    logic                dp_cur, blank;
    logic [N_DIGITS-1:0] sel_oh;
    logic [SEG7_W-1:0]   glyph, glyph_eff;
    logic [SEG7_W-1:0]   seg_r;
    logic                dp_r, tick_r;
    logic [N_DIGITS-1:0] sel_r;
`ifdef SEG7_LZ_BLANK_EN
    logic                zero_above;
`endif

    assign tc   = (prescaler == PS_W'(SCAN_DIV - 1));
    assign last = (idx == IDX_W'(N_DIGITS - 1));
    assign wrap = tc && last;

    always_comb begin
        nibble = '0;
        dp_cur = 1'b0;
        sel_oh = '0;
        blank  = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                nibble    = display.value[4*k +: 4];
                dp_cur    = display.dp[k];
                sel_oh[k] = 1'b1;
            end
        end
`ifdef SEG7_LZ_BLANK_EN
        // Walk from the top digit down; a digit blanks only if it and everything above it is zero.
        zero_above = 1'b1;
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            zero_above = zero_above && (display.value[4*k +: 4] == 4'h0);
            if (idx == IDX_W'(k)) blank = zero_above;
        end
`endif
    end

    seg7_hex_decode u_dec (.nibble(nibble), .glyph(glyph));

    assign glyph_eff = blank ? SEG7_BLANK : glyph;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            idx       <= '0;
            pending   <= '0;
            display   <= '0;
            tick_r    <= 1'b0;
            seg_r     <= SEG_XOR;
            dp_r      <= DP_XOR;
            sel_r     <= SEL_XOR;
        end else begin
            prescaler <= tc ? '0 : prescaler + 1'b1;
            if (tc) idx <= last ? '0 : idx + 1'b1;
            if (load_q()) pending <= '{value: bus.value, dp: bus.dp_in};
            // Display only moves at the frame boundary, so a frame is never torn.
            if (wrap) display <= pending;
            tick_r <= wrap;
            seg_r  <= glyph_eff ^ SEG_XOR;
            dp_r   <= dp_cur ^ DP_XOR;
            sel_r  <= sel_oh ^ SEL_XOR;
        end
    end

    function automatic logic load_q();
        return bus.load;
    endfunction

    assign bus.seg        = seg_r;
    assign bus.dp         = dp_r;
    assign bus.sel        = sel_r;
    assign bus.frame_tick = tick_r;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: active-high instance plus an active-low instance for reset checks.
module tb_seg7_scan_driver;
    import seg7_pkg::*;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.N_DIGITS(4)) bus ();
    seg7_scan_driver_if #(.N_DIGITS(4)) busn ();

    seg7_scan_driver #(.N_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_HIGH(1'b1), .SEL_ACTIVE_HIGH(1'b1))
        dut (.clk(clk), .rst(rst), .bus(bus.slave));
    seg7_scan_driver #(.N_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_HIGH(1'b0), .SEL_ACTIVE_HIGH(1'b0))
        dut_n (.clk(clk), .rst(rst2), .bus(busn.slave));

`ifdef SEG7_LZ_BLANK_EN
    localparam logic [6:0] Z = 7'h00;
`else
    localparam logic [6:0] Z = 7'h3F;
`endif
    localparam logic [6:0] ZN = ~Z;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int nt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the negedge following posedge number k after release.
    task automatic go(input int k);
        while (cyc < k) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic ld(input logic [15:0] v, input logic [3:0] d);
        bus.load = 1'b1; bus.value = v; bus.dp_in = d;
        go(cyc + 1);
        bus.load = 1'b0;
    endtask

    task automatic ldn(input logic [15:0] v, input logic [3:0] d);
        busn.load = 1'b1; busn.value = v; busn.dp_in = d;
        go(cyc + 1);
        busn.load = 1'b0;
    endtask

    initial begin
        bus.load = 1'b0;  bus.value = '0;  bus.dp_in = '0;
        busn.load = 1'b0; busn.value = '0; busn.dp_in = '0;

        // 1. reset and scan order
        repeat (3) @(negedge clk);
        chk("rst_sel", bus.sel, 4'b0000);
        chk("rst_seg", bus.seg, 7'h00);
        chk("rst_dp", bus.dp, 1'b0);
        chk("rst_tick", bus.frame_tick, 1'b0);
        chk("rstn_sel", busn.sel, 4'b1111);
        chk("rstn_seg", busn.seg, 7'h7F);
        chk("rstn_dp", busn.dp, 1'b1);
        rst = 1'b0; rst2 = 1'b0;
        go(1);  chk("first_sel", bus.sel, 4'b0001); chk("first_seg", bus.seg, 7'h3F);
        go(4);  chk("hold_sel", bus.sel, 4'b0001);
        go(5);  chk("step1_sel", bus.sel, 4'b0010);
        go(9);  chk("step2_sel", bus.sel, 4'b0100);
        go(13); chk("step3_sel", bus.sel, 4'b1000); chk("step3_seg", bus.seg, Z);

        // 2. mid-frame load is held until the wrap
        go(14); ld(16'h1A2F, 4'b0100);
        chk("old_held_seg", bus.seg, Z);
        chk("pre_tick", bus.frame_tick, 1'b0);
        go(16); chk("wrap_tick", bus.frame_tick, 1'b1); chk("wrap_seg_old", bus.seg, Z);
        go(17); chk("f1_d0_seg", bus.seg, 7'h71); chk("f1_d0_sel", bus.sel, 4'b0001);
        chk("f1_d0_dp", bus.dp, 1'b0); chk("post_tick", bus.frame_tick, 1'b0);
        go(21); chk("f1_d1_seg", bus.seg, 7'h5B);
        go(25); chk("f1_d2_seg", bus.seg, 7'h77); chk("f1_d2_dp", bus.dp, 1'b1);
        go(29); chk("f1_d3_seg", bus.seg, 7'h06); chk("f1_d3_dp", bus.dp, 1'b0);

        // 3. two loads in one frame: last wins, shown next frame
        go(34); ld(16'h1111, 4'b0000);
        go(38); ld(16'h2222, 4'b0000);
        go(41); chk("multi_old_seg", bus.seg, 7'h77); chk("multi_old_sel", bus.sel, 4'b0100);
        go(49); chk("multi_d0_seg", bus.seg, 7'h5B);
        go(53); chk("multi_d1_seg", bus.seg, 7'h5B);

        // 4. load coincident with the wrap
        go(56); ld(16'h5555, 4'b0000);
        go(63); ld(16'h0BED, 4'b0001);
        chk("coin_tick", bus.frame_tick, 1'b1);
        go(65); chk("coin_d0_seg", bus.seg, 7'h6D);
        go(69); chk("coin_d1_seg", bus.seg, 7'h6D);
        go(79); chk("coin_pre_tick", bus.frame_tick, 1'b0);
        go(80); chk("coin_wrap_tick", bus.frame_tick, 1'b1);
        go(81); chk("late_d0_seg", bus.seg, 7'h5E); chk("late_d0_dp", bus.dp, 1'b1);
        go(85); chk("late_d1_seg", bus.seg, 7'h79); chk("late_d1_dp", bus.dp, 1'b0);
        go(89); chk("late_d2_seg", bus.seg, 7'h7C);
        go(93); chk("late_d3_seg", bus.seg, Z);

        // 5. leading zeros (blanked only when the option is built in)
        go(96); ld(16'h0050, 4'b0000);
        nt = int'(bus.frame_tick);
        while (cyc < 112) begin
            go(cyc + 1);
            nt += int'(bus.frame_tick);
        end
        chk("tick_per_frame", nt, 1);
        go(113); ld(16'h0000, 4'b0000);
        chk("lz_d0_seg", bus.seg, 7'h3F);
        go(117); chk("lz_d1_seg", bus.seg, 7'h6D);

        // 6. active-low instance, reset asserted mid-frame with data pending
        go(120); ldn(16'h00F3, 4'b0000);
        chk("lz_d2_seg", bus.seg, Z);
        chk("n_pre_sel", busn.sel, 4'b1011);
        chk("n_pre_seg", busn.seg, ZN);
        chk("n_pre_dp", busn.dp, 1'b1);
        go(122); rst2 = 1'b1; #1;
        chk("n_rst_seg", busn.seg, 7'h7F);
        chk("n_rst_dp", busn.dp, 1'b1);
        chk("n_rst_sel", busn.sel, 4'b1111);
        go(124); rst2 = 1'b0;
        go(125); chk("lz_d3_seg", bus.seg, Z);
        chk("n_first_sel", busn.sel, 4'b1110); chk("n_first_seg", busn.seg, 7'h40);
        go(129); chk("zero_d0_seg", bus.seg, 7'h3F);
        go(133); chk("zero_d1_seg", bus.seg, Z);
        go(140); chk("n_wrap_tick", busn.frame_tick, 1'b1);
        go(141); chk("n_discard_d0", busn.seg, 7'h40); chk("n_discard_sel", busn.sel, 4'b1110);
        go(145); chk("n_discard_d1", busn.seg, ZN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
